kbd_event_fifo: RTL and testbench

//  Downstream stage of the Keyboard block. Samples its one-cycle cur_key code word and turns each new key code into a

---
 rtl/kbd_pkg.sv | 21 ++
 rtl/kbd_ascii_rom.sv | 49 ++++
 rtl/kbd_event_fifo.sv | 116 +++++++++++
 tb/tb_kbd_event_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the keyboard event path.
package kbd_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;

  // Bit layout is the CPU-visible rd_data word.
  typedef struct packed {
    logic [7:0] ascii;
    logic       brk;
    logic       ext;
    logic       shift;
    logic       caps;
    logic [3:0] rsvd;
    logic [7:0] scancode;
  } kbd_event_t;

endpackage

// File: rtl/kbd_ascii_rom.sv
// Set-2 scancode to ASCII lookup; only built when KBD_ASCII_EN is defined.
module kbd_ascii_rom (
  input  logic [7:0] scancode,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  // ent = {is_letter, unshifted, shifted}
  logic [16:0] ent;

  always_comb begin
    ent = '0;
    case (scancode)
      8'h1C: ent = {1'b1, "a", "A"};  8'h32: ent = {1'b1, "b", "B"};
      8'h21: ent = {1'b1, "c", "C"};  8'h23: ent = {1'b1, "d", "D"};
      8'h24: ent = {1'b1, "e", "E"};  8'h2B: ent = {1'b1, "f", "F"};
      8'h34: ent = {1'b1, "g", "G"};  8'h33: ent = {1'b1, "h", "H"};
      8'h43: ent = {1'b1, "i", "I"};  8'h3B: ent = {1'b1, "j", "J"};
      8'h42: ent = {1'b1, "k", "K"};  8'h4B: ent = {1'b1, "l", "L"};
      8'h3A: ent = {1'b1, "m", "M"};  8'h31: ent = {1'b1, "n", "N"};
      8'h44: ent = {1'b1, "o", "O"};  8'h4D: ent = {1'b1, "p", "P"};
      8'h15: ent = {1'b1, "q", "Q"};  8'h2D: ent = {1'b1, "r", "R"};
      8'h1B: ent = {1'b1, "s", "S"};  8'h2C: ent = {1'b1, "t", "T"};
      8'h3C: ent = {1'b1, "u", "U"};  8'h2A: ent = {1'b1, "v", "V"};
      8'h1D: ent = {1'b1, "w", "W"};  8'h22: ent = {1'b1, "x", "X"};
      8'h35: ent = {1'b1, "y", "Y"};  8'h1A: ent = {1'b1, "z", "Z"};
      8'h16: ent = {1'b0, "1", "!"};  8'h1E: ent = {1'b0, "2", "@"};
      8'h26: ent = {1'b0, "3", "#"};  8'h25: ent = {1'b0, "4", "$"};
      8'h2E: ent = {1'b0, "5", "%"};  8'h36: ent = {1'b0, "6", "^"};
      8'h3D: ent = {1'b0, "7", "&"};  8'h3E: ent = {1'b0, "8", "*"};
      8'h46: ent = {1'b0, "9", "("};  8'h45: ent = {1'b0, "0", ")"};
      8'h4E: ent = {1'b0, "-", "_"};  8'h55: ent = {1'b0, "=", "+"};
      8'h54: ent = {1'b0, "[", "{"};  8'h5B: ent = {1'b0, "]", "}"};
      8'h5D: ent = {1'b0, "\\", "|"}; 8'h4C: ent = {1'b0, ";", ":"};
      8'h52: ent = {1'b0, "'", "\""}; 8'h0E: ent = {1'b0, 8'h60, "~"};
      8'h41: ent = {1'b0, ",", "<"};  8'h49: ent = {1'b0, ".", ">"};
      8'h4A: ent = {1'b0, "/", "?"};  8'h29: ent = {1'b0, " ", " "};
      8'h5A: ent = {1'b0, 8'h0D, 8'h0D};
      default: ent = '0;
    endcase
  end

  logic up;
  assign up    = ent[16] ? (shift ^ caps) : shift;
  assign ascii = ext ? 8'h00 : (up ? ent[7:0] : ent[15:8]);

endmodule

// File: rtl/kbd_event_fifo.sv
// Decodes one-cycle keyboard code words into events and queues them for CPU polling.
// Define KBD_ASCII_EN to fill the ascii field from kbd_ascii_rom; otherwise it reads 0.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [31:0]   cur_key,
  input  logic          rd_en,
  input  logic          ovf_clr,
  output logic [23:0]   rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          shift,
  output logic          caps
);

  logic [31:0] key_q;
  logic        shift_l, shift_r, caps_q, caps_held, ovf_q;
  logic [AW:0] wr_ptr, rd_ptr;
  kbd_event_t  mem [DEPTH];
  kbd_event_t  ev;

  logic [7:0] code, ev_ascii;
  logic       ev_vld, brk, ext, push, pop, drop;

  assign code   = cur_key[7:0];
  assign ev_vld = (code != 8'h00) && (cur_key != key_q);
  assign brk    = (cur_key[15:8] == PFX_BRK);
  assign ext    = (cur_key[15:8] == PFX_EXT) || (cur_key[23:16] == PFX_EXT);

`ifdef KBD_ASCII_EN
  logic [7:0] rom_ascii;
  kbd_ascii_rom u_rom (
    .scancode (code),
    .ext      (ext),
    .shift    (shift),
    .caps     (caps_q),
    .ascii    (rom_ascii)
  );
  assign ev_ascii = brk ? 8'h00 : rom_ascii;
`else
  assign ev_ascii = 8'h00;
`endif

  // Flags carry the modifier state as it was before this event lands.
  always_comb begin
    ev          = '0;
    ev.ascii    = ev_ascii;
    ev.brk      = brk;
    ev.ext      = ext;
    ev.shift    = shift;
    ev.caps     = caps_q;
    ev.scancode = code;
  end

  // A simultaneous pop frees the slot, so a full FIFO still accepts when rd_en is high.
  assign pop  = rd_en && !empty;
  assign push = ev_vld && (!full || rd_en);
  assign drop = ev_vld && full && !rd_en;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_q     <= '0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_q    <= 1'b0;
      caps_held <= 1'b0;
    end else begin
      key_q <= cur_key;
      if (ev_vld && !ext) begin
        if (code == SC_LSHIFT) shift_l <= !brk;
        if (code == SC_RSHIFT) shift_r <= !brk;
        // caps_held suppresses retoggling on typematic repeats of the make code
        if (code == SC_CAPS) begin
          if (brk)             caps_held <= 1'b0;
          else if (!caps_held) begin
            caps_q    <= ~caps_q;
            caps_held <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push)         wr_ptr <= wr_ptr + 1'b1;
      if (pop)          rd_ptr <= rd_ptr + 1'b1;
      if (drop)         ovf_q  <= 1'b1;
      else if (ovf_clr) ovf_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev;
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign rd_data  = empty ? 24'h0 : mem[rd_ptr[AW-1:0]];
  assign overflow = ovf_q;
  assign shift    = shift_l | shift_r;
  assign caps     = caps_q;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Scoreboard bench for kbd_event_fifo: stimulus queues expected entries, a monitor checks each pop.
module tb_kbd_event_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

`ifdef KBD_ASCII_EN
  localparam logic [7:0] A_LO = 8'h61;
  localparam logic [7:0] A_UP = 8'h41;
`else
  localparam logic [7:0] A_LO = 8'h00;
  localparam logic [7:0] A_UP = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          clrn;
  logic [31:0]   cur_key;
  logic          rd_en, ovf_clr;
  logic [23:0]   rd_data;
  logic          empty, full, overflow, shift, caps;
  logic [AW:0]   count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [23:0] exp_q[$];

  kbd_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn), .cur_key(cur_key), .rd_en(rd_en), .ovf_clr(ovf_clr),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .shift(shift), .caps(caps)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [7:0] asc, input logic b, input logic e,
                                     input logic s, input logic c, input logic [7:0] sc);
    return {asc, b, e, s, c, 4'b0, sc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (clrn && rd_en && !empty) begin
      if (exp_q.size() == 0) chk("unexpected_pop", {8'h0, rd_data}, 32'hFFFF_FFFF);
      else chk("pop_data", {8'h0, rd_data}, {8'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] k, input logic [23:0] e);
    cur_key = k;
    exp_q.push_back(e);
    tick();
    cur_key = '0;
    tick();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    @(negedge clk);
    chk("drained_empty", 32'(empty), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clrn = 1'b0; cur_key = '0; rd_en = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_shift",    32'(shift),    32'd0);
    chk("rst_caps",     32'(caps),     32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    @(posedge clk); #1;
    clrn = 1'b1;
    tick();

    // single make code; visible the cycle after capture
    cur_key = 32'h1C;
    exp_q.push_back(mk(A_LO, 0, 0, 0, 0, 8'h1C));
    tick();
    cur_key = '0;
    @(negedge clk);
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_head",  32'(rd_data), 32'(mk(A_LO, 0, 0, 0, 0, 8'h1C)));
    tick();
    drain(1);

    // shifted letter
    send(32'h12,   mk(8'h00, 0, 0, 0, 0, 8'h12));
    send(32'h1C,   mk(A_UP,  0, 0, 1, 0, 8'h1C));
    send(32'hF01C, mk(8'h00, 1, 0, 1, 0, 8'h1C));
    @(negedge clk);
    chk("t2_shift_held", 32'(shift), 32'd1);
    tick();
    send(32'hF012, mk(8'h00, 1, 0, 1, 0, 8'h12));
    @(negedge clk);
    chk("t2_shift_rel", 32'(shift), 32'd0);
    chk("t2_count",     32'(count), 32'd4);
    tick();
    drain(4);

    // caps lock with typematic repeats
    send(32'h58, mk(8'h00, 0, 0, 0, 0, 8'h58));
    @(negedge clk);
    chk("t3_caps_on", 32'(caps), 32'd1);
    tick();
    send(32'h58,   mk(8'h00, 0, 0, 0, 1, 8'h58));
    send(32'h58,   mk(8'h00, 0, 0, 0, 1, 8'h58));
    send(32'hF058, mk(8'h00, 1, 0, 0, 1, 8'h58));
    @(negedge clk);
    chk("t3_caps_kept", 32'(caps), 32'd1);
    tick();
    send(32'h58,   mk(8'h00, 0, 0, 0, 1, 8'h58));
    send(32'hF058, mk(8'h00, 1, 0, 0, 0, 8'h58));
    @(negedge clk);
    chk("t3_caps_off", 32'(caps),  32'd0);
    chk("t3_count",    32'(count), 32'd6);
    tick();
    drain(6);

    // extended keys, including extended 0x12 which must not touch shift
    send(32'hE074,   mk(8'h00, 0, 1, 0, 0, 8'h74));
    send(32'hE0F074, mk(8'h00, 1, 1, 0, 0, 8'h74));
    send(32'hE012,   mk(8'h00, 0, 1, 0, 0, 8'h12));
    @(negedge clk);
    chk("t4_ext_shift", 32'(shift), 32'd0);
    tick();
    send(32'hE0F012, mk(8'h00, 1, 1, 0, 0, 8'h12));
    drain(4);

    // overflow: DEPTH+2 back-to-back events, last two dropped
    for (int i = 0; i < DEPTH + 2; i++) begin
      cur_key = 32'hF060 + 32'(i);
      if (i < DEPTH) exp_q.push_back(mk(8'h00, 1, 0, 0, 0, 8'h60 + 8'(i)));
      tick();
    end
    cur_key = '0;
    @(negedge clk);
    chk("t5_full",     32'(full),     32'd1);
    chk("t5_count",    32'(count),    32'(DEPTH));
    chk("t5_overflow", 32'(overflow), 32'd1);
    tick();
    drain(DEPTH);
    @(negedge clk);
    chk("t5_ovf_sticky",  32'(overflow), 32'd1);
    chk("t5_rd_data_emp", 32'(rd_data),  32'd0);
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    chk("t5_rd_empty_cnt", 32'(count), 32'd0);
    chk("t5_rd_empty_emp", 32'(empty), 32'd1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    tick();

    // fill with caps on, then drop+clear race and push+pop while full
    send(32'h58,   mk(8'h00, 0, 0, 0, 0, 8'h58));
    send(32'hF058, mk(8'h00, 1, 0, 0, 1, 8'h58));
    for (int i = 0; i < DEPTH - 2; i++) begin
      cur_key = 32'hF080 + 32'(i);
      exp_q.push_back(mk(8'h00, 1, 0, 0, 1, 8'h80 + 8'(i)));
      tick();
    end
    cur_key = '0;
    tick();
    cur_key = 32'hF0A0;
    ovf_clr = 1'b1;
    tick();
    cur_key = '0;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("t6_drop_wins", 32'(overflow), 32'd1);
    chk("t6_drop_cnt",  32'(count),    32'(DEPTH));
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    cur_key = 32'hF0B0;
    rd_en   = 1'b1;
    exp_q.push_back(mk(8'h00, 1, 0, 0, 1, 8'hB0));
    tick();
    cur_key = '0;
    rd_en   = 1'b0;
    @(negedge clk);
    chk("t6_pp_count", 32'(count),    32'(DEPTH));
    chk("t6_pp_full",  32'(full),     32'd1);
    chk("t6_pp_ovf",   32'(overflow), 32'd0);
    chk("t6_caps_set", 32'(caps),     32'd1);
    tick();

    // async reset in the middle of a cycle
    cur_key = 32'hF0C0;
    rd_en   = 1'b1;
    #2;
    clrn = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(empty),    32'd1);
    chk("t6_rst_count", 32'(count),    32'd0);
    chk("t6_rst_caps",  32'(caps),     32'd0);
    chk("t6_rst_ovf",   32'(overflow), 32'd0);
    chk("t6_rst_data",  32'(rd_data),  32'd0);
    exp_q.delete();
    rd_en   = 1'b0;
    cur_key = '0;
    tick();
    clrn = 1'b1;
    tick();
    send(32'h1C, mk(A_LO, 0, 0, 0, 0, 8'h1C));
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
